// File: rtl/program_loader_if.sv
// Byte-stream handshake between the host feeder and the program loader.
// The host drives byte_valid/byte_data and the loader answers with byte_ready;
// a byte transfers on a rising clock edge when byte_valid && byte_ready.
interface program_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

// File: rtl/program_loader.sv
// Program loader: receives a 16-bit big-endian word count followed by
// big-endian instruction words over a byte stream, writes each word to
// instruction memory at consecutive word addresses starting at BASE_ADDR,
// and keeps the core in reset (PC_reset high) until the whole program is in.
// An illegal count (zero or above MAX_WORDS) parks the loader in ERROR;
// DONE and ERROR are left only through a start pulse (or reset).
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic                   clock,
  input  logic                   reset,
  program_loader_if.slave        host,
  input  logic                   start,
  output logic                   inst_memory_load_enable,
  output logic [31:0]            inst_memory_write_addr,
  output logic [31:0]            inst_memory_write_data,
  output logic                   PC_reset,
  output logic                   load_done,
  output logic                   load_error
);

  localparam int          IDX_W     = $clog2(MAX_WORDS + 1);
  localparam logic [15:0] MAX_COUNT = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t             state;
  logic [15:0]        count;
  logic [IDX_W-1:0]   index;
  logic [1:0]         byte_cnt;
  logic [31:0]        shift_reg;

  logic               accept;
  logic [15:0]        full_count;
  logic [31:0]        next_word;
  logic               last_word;

  // The host may only push bytes while we are collecting the header or data;
  // the ready decode looks at the state alone, never at byte_valid.
  assign host.byte_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
  assign accept          = host.byte_valid && host.byte_ready;

  // Count as it will look once the low byte currently on the bus lands.
  assign full_count = {count[15:8], host.byte_data};
  // Big-endian packing: the first byte of a word ends up in bits [31:24].
  assign next_word  = {shift_reg[23:0], host.byte_data};
  // Compare at 17 bits so index+1 cannot wrap before being checked.
  assign last_word  = (17'(index) + 17'd1) == {1'b0, count};

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                   <= LEN_HI;
      count                   <= 16'h0000;
      index                   <= '0;
      byte_cnt                <= 2'd0;
      shift_reg               <= 32'h0000_0000;
      inst_memory_load_enable <= 1'b0;
      inst_memory_write_addr  <= BASE_ADDR;
      inst_memory_write_data  <= 32'h0000_0000;
      PC_reset                <= 1'b1;
      load_done               <= 1'b0;
      load_error              <= 1'b0;
    end else begin
      case (state)
        LEN_HI: begin
          if (accept) begin
            count[15:8] <= host.byte_data;
            state       <= LEN_LO;
          end
        end

        LEN_LO: begin
          if (accept) begin
            count[7:0] <= host.byte_data;
            if ((full_count == 16'h0000) || (full_count > MAX_COUNT)) begin
              load_error <= 1'b1;
              state      <= ERROR;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (accept) begin
            shift_reg <= next_word;
            if (byte_cnt == 2'd3) begin
              inst_memory_write_data  <= next_word;
              inst_memory_write_addr  <= BASE_ADDR + (32'(index) << 2);
              inst_memory_load_enable <= 1'b1;
              byte_cnt                <= 2'd0;
              state                   <= WRITE;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end

        WRITE: begin
          inst_memory_load_enable <= 1'b0;
          index                   <= index + 1'b1;
          if (last_word) begin
            PC_reset  <= 1'b0;
            load_done <= 1'b1;
            state     <= DONE;
          end else begin
            state <= DATA;
          end
        end

        DONE, ERROR: begin
          if (start) begin
            PC_reset   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            index      <= '0;
            byte_cnt   <= 2'd0;
            state      <= LEN_HI;
          end
        end

        default: begin
          state <= LEN_HI;
        end
      endcase
    end
  end

endmodule
